// File: rtl/frame_transfer.sv
// -----------------------------------------------------------------------------
// frame_transfer
//
// Copy stage between the next-target framebuffer (filled by the protocol
// receiver) and the target framebuffer (read by the animator). Once a full
// frame has arrived, the block waits for the next driver latch boundary.
// It then streams all c_ledboards*32 channel values from the next buffer into
// the target buffer, together with the frame's time and type tags.
//
// Optional build macro:
//   FRAME_TRANSFER_IMMEDIATE_EN - when defined, the copy starts one cycle after
//   the frame is armed and does not wait for a latch edge (i_lat is unused).
//   When undefined (default), the swap is synchronised to the rising i_lat.
//
// Ports:
//   i_clk        system clock (2 MHz); all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_frame_done one-cycle pulse: a complete frame is in the next buffer
//   i_lat        driver latch; a rising edge marks the frame boundary
//   i_rdata      next-buffer read data, valid one cycle after o_raddr
//   i_time       next-buffer time tag
//   i_type       next-buffer type tag
//   o_raddr      next-buffer read address (0 whenever no copy is running)
//   o_wen        target-buffer write enable
//   o_waddr      target-buffer write address (0 outside the write window)
//   o_wdata      target-buffer write data (0 outside the write window)
//   o_time       time tag captured at the start of the copy
//   o_type       type tag captured at the start of the copy
//   o_busy       high while copying and during the final flush cycle
//   o_swapped    one-cycle pulse: transfer complete
//   o_overrun    one-cycle pulse: a frame arrived while one was already pending
// -----------------------------------------------------------------------------
module frame_transfer #(
    parameter  int c_ledboards = 30,
    parameter  int c_bpc       = 12,
    parameter  int c_max_time  = 1024,
    parameter  int c_max_type  = 64,
    localparam int c_channels  = c_ledboards * 32,
    localparam int c_addr_w    = $clog2(c_channels),
    localparam int c_time_w    = $clog2(c_max_time),
    localparam int c_type_w    = $clog2(c_max_type)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_frame_done,
    input  logic                i_lat,
    input  logic [c_bpc-1:0]    i_rdata,
    input  logic [c_time_w-1:0] i_time,
    input  logic [c_type_w-1:0] i_type,
    output logic [c_addr_w-1:0] o_raddr,
    output logic                o_wen,
    output logic [c_addr_w-1:0] o_waddr,
    output logic [c_bpc-1:0]    o_wdata,
    output logic [c_time_w-1:0] o_time,
    output logic [c_type_w-1:0] o_type,
    output logic                o_busy,
    output logic                o_swapped,
    output logic                o_overrun
);

    localparam logic [c_addr_w-1:0] c_last = c_addr_w'(c_channels - 1);
    localparam logic [c_addr_w-1:0] c_zero = {c_addr_w{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_COPY  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                pending_r;
    logic                pending_s;
    logic                lat_q_r;
    logic                go_s;
    logic                start_s;
    logic                overrun_s;
    logic                last_s;
    logic                copy_s;
    logic [c_addr_w-1:0] raddr_s;

`ifdef FRAME_TRANSFER_IMMEDIATE_EN
    // Armed frames are copied straight away; the latch input plays no part.
    assign go_s = 1'b1;
`else
    // Rising latch edge, usable in the same cycle it is seen.
    assign go_s = i_lat & ~lat_q_r;
`endif

    assign copy_s = (state_r == ST_COPY);
    // The address counter stops at the last channel and never wraps.
    assign last_s = (o_raddr == c_last);

    // Next-state, pending-frame and overrun decode.
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r;
        overrun_s = 1'b0;
        start_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A latch edge arriving together with the frame does not start
                // the copy; the frame only becomes armed.
                if (i_frame_done) begin
                    state_s = ST_ARMED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                // A second frame simply overwrites the armed one in the buffer.
                if (i_frame_done) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = 1'b0;
                end
                if (go_s) begin
                    state_s = ST_COPY;
                    start_s = 1'b1;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_COPY: begin
                if (i_frame_done) begin
                    pending_s = 1'b1;
                    overrun_s = pending_r;
                end else begin
                    pending_s = pending_r;
                end
                if (last_s) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_COPY;
                end
            end
            ST_FLUSH: begin
                // A frame landing in the flush cycle counts as pending too.
                overrun_s = i_frame_done & pending_r;
                if (pending_r || i_frame_done) begin
                    state_s = ST_ARMED;
                end else begin
                    state_s = ST_IDLE;
                end
                pending_s = 1'b0;
            end
            default: begin
                state_s   = ST_IDLE;
                pending_s = 1'b0;
            end
        endcase
    end

    // Next read address: counts only while copying, otherwise parked at 0 so
    // the bus can be OR-merged with other address sources.
    always_comb begin
        raddr_s = c_zero;
        if (copy_s && !last_s) begin
            raddr_s = o_raddr + c_addr_w'(1);
        end else begin
            raddr_s = c_zero;
        end
    end

    // Control state, latch history and status pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            pending_r <= 1'b0;
            lat_q_r   <= 1'b0;
            o_busy    <= 1'b0;
            o_swapped <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            lat_q_r   <= i_lat;
            o_busy    <= (state_s == ST_COPY) || (state_s == ST_FLUSH);
            o_swapped <= (state_s == ST_FLUSH);
            o_overrun <= overrun_s;
        end
    end

    // Read address and the write side, which trails the read side by the
    // one-cycle read latency of the next buffer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_raddr <= c_zero;
            o_wen   <= 1'b0;
            o_waddr <= c_zero;
        end else begin
            o_raddr <= raddr_s;
            o_wen   <= copy_s;
            o_waddr <= copy_s ? o_raddr : c_zero;
        end
    end

    // Frame tags are captured once at copy start and held until the next one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_time <= {c_time_w{1'b0}};
            o_type <= {c_type_w{1'b0}};
        end else if (start_s) begin
            o_time <= i_time;
            o_type <= i_type;
        end else begin
            o_time <= o_time;
            o_type <= o_type;
        end
    end

    // Read data already arrives in the write cycle, so it passes straight
    // through; it is forced to 0 outside the write window.
    assign o_wdata = o_wen ? i_rdata : {c_bpc{1'b0}};

endmodule

// File: tb/tb_frame_transfer.sv
`timescale 1ns/1ps
module tb_frame_transfer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fd  = 1'b0;
    logic        lat = 1'b0;
    logic [11:0] rdata = 12'h000;
    logic [9:0]  tm = 10'd300;
    logic [5:0]  ty = 6'd5;
    logic [9:0]  raddr, waddr, otime;
    logic [11:0] wdata;
    logic [5:0]  otype;
    logic        wen, busy, swapped, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor statistics
    int wr_cnt = 0, wr_bad = 0, swap_cnt = 0, ovr_cnt = 0, iface_bad = 0;
    int exp_waddr = 0;

    always #250 clk = ~clk;

    frame_transfer dut (
        .i_clk(clk), .i_rst(rst), .i_frame_done(fd), .i_lat(lat),
        .i_rdata(rdata), .i_time(tm), .i_type(ty),
        .o_raddr(raddr), .o_wen(wen), .o_waddr(waddr), .o_wdata(wdata),
        .o_time(otime), .o_type(otype), .o_busy(busy),
        .o_swapped(swapped), .o_overrun(overrun)
    );

    // Next-buffer model: data[a] = a ^ 12'hA5A, one-cycle read latency.
    always @(posedge clk) rdata <= {2'b00, raddr} ^ 12'hA5A;

    // Write-side monitor: contiguity, data and interface-idle rules.
    always @(posedge clk) begin
        #1;
        if (wen) begin
            if (int'(waddr) != exp_waddr || wdata != ({2'b00, waddr} ^ 12'hA5A) || !busy)
                wr_bad++;
            exp_waddr = int'(waddr) + 1;
            wr_cnt++;
        end
        if (!busy) exp_waddr = 0;
        if (swapped) swap_cnt++;
        if (overrun) ovr_cnt++;
        if ((!busy || swapped) && raddr != 10'd0) iface_bad++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Start a copy with a latch edge and run it to o_swapped, optionally
    // injecting frame_done, extra latch edges or a reset after the n-th write.
    task automatic run_copy(input string name, input int fd_at, input int la, input int lb,
                            input int rst_at, output int cyc);
        int w0;
        bit f_fd, f_la, f_lb, f_rst, done;
        w0 = wr_cnt; f_fd = 0; f_la = 0; f_lb = 0; f_rst = 0; done = 0;
        lat = 1'b1;
        step();
        lat = 1'b0;
        cyc = 1;
        while (!done && cyc < 1100) begin
            int wd;
            wd = wr_cnt - w0;
            fd = 1'b0; lat = 1'b0; rst = 1'b0;
            if (wd == fd_at && !f_fd) begin fd = 1'b1; f_fd = 1; end
            if (wd == la && !f_la) begin lat = 1'b1; f_la = 1; end
            if (wd == lb && !f_lb) begin lat = 1'b1; f_lb = 1; end
            if (wd == rst_at && !f_rst) begin rst = 1'b1; f_rst = 1; end
            step();
            cyc++;
            if (swapped || rst) done = 1;
        end
        fd = 1'b0; lat = 1'b0; rst = 1'b0;
        check({name, " completes"}, done, 1);
    endtask

    task automatic frame_pulse();
        fd = 1'b1;
        step();
        fd = 1'b0;
    endtask

    typedef struct {
        logic       rst, fd, lat;
        logic [9:0] tm;
        logic [5:0] ty;
        logic [39:0] exp;   // {busy,wen,raddr,waddr,swapped,overrun,time,type}
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(int r, int f, int l, int t, int y, int b, int w,
                                int ra, int wa, int s, int o, int et, int ey);
        vec_t v;
        v.rst = r[0]; v.fd = f[0]; v.lat = l[0];
        v.tm = t[9:0]; v.ty = y[5:0];
        v.exp = {b[0], w[0], ra[9:0], wa[9:0], s[0], o[0], et[9:0], ey[5:0]};
        return v;
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, w0, s0, o0, b0, busy_seen;

        //            rst fd lat  tm  ty | busy wen raddr waddr swp ovr time type
        tbl[0]  = mk(1, 0, 0, 300, 5,  0, 0, 0, 0, 0, 0,   0, 0);
        tbl[1]  = mk(0, 0, 1, 300, 5,  0, 0, 0, 0, 0, 0,   0, 0); // lat in IDLE ignored
        tbl[2]  = mk(0, 1, 0, 300, 5,  0, 0, 0, 0, 0, 0,   0, 0); // -> ARMED
        tbl[3]  = mk(0, 1, 0, 300, 5,  0, 0, 0, 0, 0, 1,   0, 0); // overrun in ARMED
        tbl[4]  = mk(0, 0, 0, 300, 5,  0, 0, 0, 0, 0, 0,   0, 0);
        tbl[5]  = mk(0, 0, 1, 300, 5,  1, 0, 0, 0, 0, 0, 300, 5); // COPY entry
        tbl[6]  = mk(0, 0, 1,   7, 9,  1, 1, 1, 0, 0, 0, 300, 5); // first write, tags held
        tbl[7]  = mk(0, 0, 0,   7, 9,  1, 1, 2, 1, 0, 0, 300, 5);
        tbl[8]  = mk(0, 0, 1,   7, 9,  1, 1, 3, 2, 0, 0, 300, 5); // lat in COPY ignored
        tbl[9]  = mk(0, 1, 0,   7, 9,  1, 1, 4, 3, 0, 0, 300, 5); // pending set
        tbl[10] = mk(0, 1, 0,   7, 9,  1, 1, 5, 4, 0, 1, 300, 5); // pending again: overrun
        tbl[11] = mk(1, 0, 0,   7, 9,  0, 0, 0, 0, 0, 0,   0, 0); // reset mid-copy
        tbl[12] = mk(0, 0, 1,   7, 9,  0, 0, 0, 0, 0, 0,   0, 0);
        tbl[13] = mk(0, 0, 0,   7, 9,  0, 0, 0, 0, 0, 0,   0, 0);
        tbl[14] = mk(0, 1, 1,   7, 9,  0, 0, 0, 0, 0, 0,   0, 0); // fd+lat in IDLE: ARMED only
        tbl[15] = mk(0, 0, 1,   7, 9,  0, 0, 0, 0, 0, 0,   0, 0);
        tbl[16] = mk(0, 0, 0,   7, 9,  0, 0, 0, 0, 0, 0,   0, 0);
        tbl[17] = mk(0, 0, 1,   7, 9,  1, 0, 0, 0, 0, 0,   7, 9); // next edge starts copy
        tbl[18] = mk(0, 0, 1, 300, 5,  1, 1, 1, 0, 0, 0,   7, 9);
        tbl[19] = mk(1, 0, 0, 300, 5,  0, 0, 0, 0, 0, 0,   0, 0);

        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].rst; fd = tbl[i].fd; lat = tbl[i].lat;
            tm = tbl[i].tm; ty = tbl[i].ty;
            step();
            check($sformatf("vec%0d", i),
                  {busy, wen, raddr, waddr, swapped, overrun, otime, otype}, tbl[i].exp);
        end
        rst = 1'b0; fd = 1'b0; lat = 1'b0; tm = 10'd300; ty = 6'd5;

        // A: idle after reset
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("idle%0d", i), {wen, raddr, busy, swapped}, 13'd0);
        end

        // B: full transfer, latch edge 20 cycles after frame_done
        w0 = wr_cnt; s0 = swap_cnt; o0 = ovr_cnt; b0 = wr_bad;
        frame_pulse();
        repeat (19) step();
        run_copy("B", -1, -1, -1, -1, cyc);
        check("B swap latency", cyc, 961);
        check("B last waddr", waddr, 959);
        check("B writes", wr_cnt - w0, 960);
        check("B write order/data", wr_bad - b0, 0);
        check("B time", otime, 300);
        check("B type", otype, 5);
        check("B swaps", swap_cnt - s0, 1);
        check("B no overrun", ovr_cnt - o0, 0);
        step();
        check("B after swap", {swapped, busy, wen}, 3'b000);

        // C: frame_done at write #100 keeps a frame pending for the next edge
        w0 = wr_cnt; s0 = swap_cnt; o0 = ovr_cnt; b0 = wr_bad;
        tm = 10'd77; ty = 6'd33;
        frame_pulse();
        repeat (5) step();
        run_copy("C1", 100, -1, -1, -1, cyc);
        check("C1 latency", cyc, 961);
        repeat (5) step();
        check("C armed idle", busy, 0);
        tm = 10'd1023; ty = 6'd63;
        run_copy("C2", -1, -1, -1, -1, cyc);
        check("C2 latency", cyc, 961);
        check("C writes", wr_cnt - w0, 1920);
        check("C swaps", swap_cnt - s0, 2);
        check("C no overrun", ovr_cnt - o0, 0);
        check("C write order/data", wr_bad - b0, 0);
        check("C tags", {otime, otype}, {10'd1023, 6'd63});

        // D: two frame_done pulses while ARMED
        w0 = wr_cnt; s0 = swap_cnt; o0 = ovr_cnt;
        frame_pulse();
        repeat (3) step();
        frame_pulse();
        check("D overrun pulse", overrun, 1);
        step();
        check("D overrun one cycle", overrun, 0);
        repeat (3) step();
        run_copy("D", -1, -1, -1, -1, cyc);
        repeat (20) step();
        lat = 1'b1; step(); lat = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy) busy_seen++;
        end
        check("D single transfer", busy_seen, 0);
        check("D writes", wr_cnt - w0, 960);
        check("D swaps", swap_cnt - s0, 1);
        check("D overruns", ovr_cnt - o0, 1);

        // E: latch edges during COPY do not restart
        w0 = wr_cnt; b0 = wr_bad;
        frame_pulse();
        repeat (4) step();
        run_copy("E", -1, 10, 500, -1, cyc);
        check("E latency", cyc, 961);
        check("E writes", wr_cnt - w0, 960);
        check("E write order/data", wr_bad - b0, 0);

        // F: reset at write #400 aborts; no transfer without a new frame
        w0 = wr_cnt;
        frame_pulse();
        repeat (3) step();
        run_copy("F", -1, -1, -1, 400, cyc);
        check("F abort", {wen, busy, raddr}, 12'd0);
        check("F partial writes", wr_cnt - w0, 400);
        repeat (5) step();
        lat = 1'b1; step(); lat = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy) busy_seen++;
        end
        check("F no transfer after reset", busy_seen, 0);
        w0 = wr_cnt; b0 = wr_bad;
        frame_pulse();
        repeat (3) step();
        run_copy("F2", -1, -1, -1, -1, cyc);
        check("F2 writes", wr_cnt - w0, 960);
        check("F2 write order/data", wr_bad - b0, 0);

        check("address parked outside copy", iface_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
